// File: rtl/mem_pkg.sv
// Shared types for the two-port memory request arbiter: default widths,
// requester identity, request payload and the read-return tag.
package mem_pkg;

  localparam int unsigned MEM_DATA_WIDTH = 32;
  localparam int unsigned MEM_ADDR_WIDTH = 32;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

  typedef struct packed {
    logic                      wr;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic     valid;
    port_id_t port_id;
  } rd_tag_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester handshakes plus the single memory channel; master is the arbiter
// side, slave is the requesters/memory side.
interface mem_req_arbiter_if
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH
);

  logic                  a_req_valid;
  logic                  a_req_ready;
  logic                  a_req_wr;
  logic [ADDR_WIDTH-1:0] a_req_addr;
  logic [DATA_WIDTH-1:0] a_req_wdata;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;

  logic                  b_req_valid;
  logic                  b_req_ready;
  logic                  b_req_wr;
  logic [ADDR_WIDTH-1:0] b_req_addr;
  logic [DATA_WIDTH-1:0] b_req_wdata;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  logic                  mem_write_en;
  logic                  mem_read_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_w_data;
  logic [DATA_WIDTH-1:0] mem_r_data;

  modport master (
    input  a_req_valid, a_req_wr, a_req_addr, a_req_wdata,
    output a_req_ready, a_rvalid, a_rdata,
    input  b_req_valid, b_req_wr, b_req_addr, b_req_wdata,
    output b_req_ready, b_rvalid, b_rdata,
    output mem_write_en, mem_read_en, mem_addr, mem_w_data,
    input  mem_r_data
  );

  modport slave (
    output a_req_valid, a_req_wr, a_req_addr, a_req_wdata,
    input  a_req_ready, a_rvalid, a_rdata,
    output b_req_valid, b_req_wr, b_req_addr, b_req_wdata,
    input  b_req_ready, b_rvalid, b_rdata,
    input  mem_write_en, mem_read_en, mem_addr, mem_w_data,
    output mem_r_data
  );

endinterface

// File: rtl/rd_tag_pipe.sv
// Fixed-depth shift register carrying read-owner tags so that each tag leaves
// the pipe in the same cycle its read data appears on mem_r_data.
module rd_tag_pipe
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t [DEPTH-1:0] pipe_q;
  rd_tag_t [DEPTH-1:0] pipe_d;

  generate
    if (DEPTH == 1) begin : g_single
      assign pipe_d = tag_i;
    end else begin : g_multi
      assign pipe_d = {pipe_q[DEPTH-2:0], tag_i};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin merge of two valid/ready requesters onto one registered memory
// channel, with read data steered back to the issuing port in order.
module mem_req_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int unsigned RD_LATENCY = 1
) (
  input logic               clk,
  input logic               reset,
  mem_req_arbiter_if.master bus
);

  port_id_t              ptr_q, ptr_d;
  port_id_t              rd_port_q, rd_port_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_re_q, mem_re_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  a_rvalid_q, a_rvalid_d;
  logic                  b_rvalid_q, b_rvalid_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
  logic                  grant_a;
  logic                  grant_b;
  rd_tag_t               tag_in;
  rd_tag_t               tag_out;

  // Tag enters alongside the registered read strobe, so DEPTH equals the RAM latency.
  assign tag_in.valid   = mem_re_q;
  assign tag_in.port_id = rd_port_q;

  rd_tag_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk  (clk),
    .reset(reset),
    .tag_i(tag_in),
    .tag_o(tag_out)
  );

  always_comb begin
    // Ready is gated by reset so nothing is accepted while reset is held.
    grant_a     = reset && bus.a_req_valid && (!bus.b_req_valid || (ptr_q == PORT_A));
    grant_b     = reset && bus.b_req_valid && (!bus.a_req_valid || (ptr_q == PORT_B));

    ptr_d       = ptr_q;
    rd_port_d   = rd_port_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (grant_a) begin
      ptr_d       = PORT_B;
      rd_port_d   = PORT_A;
      mem_we_d    = bus.a_req_wr;
      mem_re_d    = !bus.a_req_wr;
      mem_addr_d  = bus.a_req_addr;
      mem_wdata_d = bus.a_req_wr ? bus.a_req_wdata : '0;
    end else if (grant_b) begin
      ptr_d       = PORT_A;
      rd_port_d   = PORT_B;
      mem_we_d    = bus.b_req_wr;
      mem_re_d    = !bus.b_req_wr;
      mem_addr_d  = bus.b_req_addr;
      mem_wdata_d = bus.b_req_wr ? bus.b_req_wdata : '0;
    end

    a_rvalid_d = tag_out.valid && (tag_out.port_id == PORT_A);
    b_rvalid_d = tag_out.valid && (tag_out.port_id == PORT_B);
    a_rdata_d  = a_rvalid_d ? bus.mem_r_data : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? bus.mem_r_data : b_rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= PORT_A;
      rd_port_q   <= PORT_A;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rd_port_q   <= rd_port_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign bus.a_req_ready  = grant_a;
  assign bus.b_req_ready  = grant_b;
  assign bus.mem_write_en = mem_we_q;
  assign bus.mem_read_en  = mem_re_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_w_data   = mem_wdata_q;
  assign bus.a_rvalid     = a_rvalid_q;
  assign bus.a_rdata      = a_rdata_q;
  assign bus.b_rvalid     = b_rvalid_q;
  assign bus.b_rdata      = b_rdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a behavioural RAM of read latency LAT;
// inputs change and outputs are sampled on the falling clock edge.
module tb_mem_req_arbiter;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  mem_req_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  mem_req_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .RD_LATENCY(LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Word-addressed RAM: writes visible to a read on the following edge.
  logic [31:0] ram [256];
  logic [31:0] rd_pipe [LAT];

  always @(posedge clk) begin
    if (bus.mem_write_en) ram[bus.mem_addr[9:2]] <= bus.mem_w_data;
    rd_pipe[0] <= bus.mem_read_en ? ram[bus.mem_addr[9:2]] : 32'h0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign bus.mem_r_data = rd_pipe[LAT-1];

  task automatic idle();
    bus.a_req_valid = 1'b0;
    bus.a_req_wr    = 1'b0;
    bus.a_req_addr  = 32'h0;
    bus.a_req_wdata = 32'h0;
    bus.b_req_valid = 1'b0;
    bus.b_req_wr    = 1'b0;
    bus.b_req_addr  = 32'h0;
    bus.b_req_wdata = 32'h0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    bus.a_req_valid = 1'b1;
    bus.b_req_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({bus.a_req_ready, bus.b_req_ready, bus.mem_write_en, bus.mem_read_en,
         bus.a_rvalid, bus.b_rvalid} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=000000", {bus.a_req_ready, bus.b_req_ready,
               bus.mem_write_en, bus.mem_read_en, bus.a_rvalid, bus.b_rvalid});
    end
    total++;
    if ({bus.mem_addr, bus.mem_w_data, bus.a_rdata, bus.b_rdata} !== 128'h0) begin
      bad++;
      $display("FAIL reset_data got addr=%h wd=%h ard=%h brd=%h want all 0",
               bus.mem_addr, bus.mem_w_data, bus.a_rdata, bus.b_rdata);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({bus.a_req_ready, bus.b_req_ready} !== 2'b10) begin
      bad++;
      $display("FAIL reset_first_grant got=%b want=10", {bus.a_req_ready, bus.b_req_ready});
    end
    idle();
  endtask

  task automatic test_contention();
    int   na = 0;
    int   nb = 0;
    logic exp_a;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    idle();
    bus.a_req_valid = 1'b1;
    bus.b_req_valid = 1'b1;
    bus.a_req_wr    = 1'b1;
    bus.b_req_wr    = 1'b1;
    bus.a_req_addr  = 32'h80;
    bus.b_req_addr  = 32'h84;
    for (int i = 0; i < 6; i++) begin
      bus.a_req_wdata = 32'hA000_0000 + 32'(i);
      bus.b_req_wdata = 32'hB000_0000 + 32'(i);
      #1;
      exp_a = ((i % 2) == 0);
      total++;
      if ({bus.a_req_ready, bus.b_req_ready} !== {exp_a, !exp_a}) begin
        bad++;
        $display("FAIL contention_grant%0d got=%b want=%b", i,
                 {bus.a_req_ready, bus.b_req_ready}, {exp_a, !exp_a});
      end
      na += int'(bus.a_req_ready);
      nb += int'(bus.b_req_ready);
      @(negedge clk);
      exp_addr = exp_a ? 32'h80 : 32'h84;
      exp_wd   = exp_a ? (32'hA000_0000 + 32'(i)) : (32'hB000_0000 + 32'(i));
      total++;
      if ({bus.mem_write_en, bus.mem_read_en, bus.mem_addr, bus.mem_w_data} !==
          {1'b1, 1'b0, exp_addr, exp_wd}) begin
        bad++;
        $display("FAIL contention_issue%0d got we=%b re=%b addr=%h wd=%h want we=1 re=0 addr=%h wd=%h",
                 i, bus.mem_write_en, bus.mem_read_en, bus.mem_addr, bus.mem_w_data,
                 exp_addr, exp_wd);
      end
    end
    idle();
    total++;
    if (na !== 3 || nb !== 3) begin
      bad++;
      $display("FAIL contention_counts got a=%0d b=%0d want a=3 b=3", na, nb);
    end
  endtask

  task automatic test_read_routing();
    idle();
    bus.a_req_valid = 1'b1;
    bus.a_req_wr    = 1'b1;
    bus.a_req_addr  = 32'h20;
    bus.a_req_wdata = 32'h1111;
    @(negedge clk);
    bus.a_req_addr  = 32'h24;
    bus.a_req_wdata = 32'h2222;
    @(negedge clk);
    idle();
    bus.b_req_valid = 1'b1;
    bus.b_req_addr  = 32'h20;
    #1;
    total++;
    if (bus.b_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL routing_b_ready got=%b want=1", bus.b_req_ready);
    end
    @(negedge clk);
    idle();
    bus.a_req_valid = 1'b1;
    bus.a_req_addr  = 32'h24;
    #1;
    total++;
    if (bus.a_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL routing_a_ready got=%b want=1", bus.a_req_ready);
    end
    @(negedge clk);
    idle();
    for (int j = 1; j <= LAT + 3; j++) begin
      @(negedge clk);
      total++;
      if ({bus.a_rvalid, bus.b_rvalid} !== {(j == LAT + 1), (j == LAT)}) begin
        bad++;
        $display("FAIL routing_rvalid_t%0d got a=%b b=%b want a=%b b=%b", j,
                 bus.a_rvalid, bus.b_rvalid, (j == LAT + 1), (j == LAT));
      end
      if (j == LAT) begin
        total++;
        if (bus.b_rdata !== 32'h1111) begin
          bad++;
          $display("FAIL routing_b_rdata got=%h want=00001111", bus.b_rdata);
        end
      end
      if (j == LAT + 1) begin
        total++;
        if (bus.a_rdata !== 32'h2222) begin
          bad++;
          $display("FAIL routing_a_rdata got=%h want=00002222", bus.a_rdata);
        end
      end
    end
  endtask

  task automatic test_write_read();
    idle();
    bus.a_req_valid = 1'b1;
    bus.a_req_wr    = 1'b1;
    bus.a_req_addr  = 32'h10;
    bus.a_req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++;
    if ({bus.mem_write_en, bus.mem_read_en, bus.mem_addr, bus.mem_w_data} !==
        {1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL wr_issue got we=%b re=%b addr=%h wd=%h want we=1 re=0 addr=10 wd=deadbeef",
               bus.mem_write_en, bus.mem_read_en, bus.mem_addr, bus.mem_w_data);
    end
    bus.a_req_wr = 1'b0;
    @(negedge clk);
    idle();
    total++;
    if ({bus.mem_write_en, bus.mem_read_en, bus.mem_addr, bus.mem_w_data} !==
        {1'b0, 1'b1, 32'h10, 32'h0}) begin
      bad++;
      $display("FAIL rd_issue got we=%b re=%b addr=%h wd=%h want we=0 re=1 addr=10 wd=0",
               bus.mem_write_en, bus.mem_read_en, bus.mem_addr, bus.mem_w_data);
    end
    for (int j = 1; j <= LAT + 3; j++) begin
      @(negedge clk);
      total++;
      if ({bus.a_rvalid, bus.b_rvalid} !== {(j == LAT + 1), 1'b0}) begin
        bad++;
        $display("FAIL wr_rd_rvalid_t%0d got a=%b b=%b want a=%b b=0", j,
                 bus.a_rvalid, bus.b_rvalid, (j == LAT + 1));
      end
      if (j == LAT + 1) begin
        total++;
        if (bus.a_rdata !== 32'hDEAD_BEEF) begin
          bad++;
          $display("FAIL wr_rd_rdata got=%h want=deadbeef", bus.a_rdata);
        end
      end
    end
  endtask

  task automatic test_cross_port();
    idle();
    bus.b_req_valid = 1'b1;
    bus.b_req_wr    = 1'b1;
    bus.b_req_addr  = 32'h30;
    bus.b_req_wdata = 32'hCAFE;
    @(negedge clk);
    idle();
    bus.a_req_valid = 1'b1;
    bus.a_req_addr  = 32'h30;
    @(negedge clk);
    idle();
    for (int j = 1; j <= LAT + 3; j++) begin
      @(negedge clk);
      total++;
      if ({bus.a_rvalid, bus.b_rvalid} !== {(j == LAT + 1), 1'b0}) begin
        bad++;
        $display("FAIL cross_rvalid_t%0d got a=%b b=%b want a=%b b=0", j,
                 bus.a_rvalid, bus.b_rvalid, (j == LAT + 1));
      end
      if (j == LAT + 1) begin
        total++;
        if (bus.a_rdata !== 32'hCAFE) begin
          bad++;
          $display("FAIL cross_rdata got=%h want=0000cafe", bus.a_rdata);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    idle();
    bus.a_req_valid = 1'b1;
    bus.a_req_addr  = 32'h10;
    @(negedge clk);
    idle();
    reset = 1'b0;
    #1;
    total++;
    if ({bus.mem_read_en, bus.a_rvalid} !== 2'b00) begin
      bad++;
      $display("FAIL midflight_async_clear got re=%b arv=%b want 0 0",
               bus.mem_read_en, bus.a_rvalid);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int j = 1; j <= LAT + 4; j++) begin
      @(negedge clk);
      total++;
      if ({bus.a_rvalid, bus.b_rvalid} !== 2'b00) begin
        bad++;
        $display("FAIL midflight_rvalid_t%0d got a=%b b=%b want 0 0", j,
                 bus.a_rvalid, bus.b_rvalid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_v;
    logic [31:0] exp_d;
    idle();
    for (int i = 0; i < 8; i++) begin
      bus.a_req_valid = 1'b1;
      bus.a_req_wr    = 1'b1;
      bus.a_req_addr  = 32'h40 + 32'(4 * i);
      bus.a_req_wdata = 32'h5000_0000 + 32'(i);
      @(negedge clk);
    end
    for (int c = 0; c < 8 + LAT + 3; c++) begin
      exp_v = (c >= 2 + LAT) && (c < 10 + LAT);
      exp_d = 32'h5000_0000 + 32'(c - 2 - LAT);
      total++;
      if ({bus.a_rvalid, bus.b_rvalid} !== {exp_v, 1'b0}) begin
        bad++;
        $display("FAIL b2b_rvalid_c%0d got a=%b b=%b want a=%b b=0", c,
                 bus.a_rvalid, bus.b_rvalid, exp_v);
      end
      if (exp_v) begin
        total++;
        if (bus.a_rdata !== exp_d) begin
          bad++;
          $display("FAIL b2b_rdata_c%0d got=%h want=%h", c, bus.a_rdata, exp_d);
        end
      end
      if (c < 8) begin
        bus.a_req_valid = 1'b1;
        bus.a_req_wr    = 1'b0;
        bus.a_req_addr  = 32'h40 + 32'(4 * c);
        #1;
        total++;
        if (bus.a_req_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready_c%0d got=%b want=1", c, bus.a_req_ready);
        end
      end else begin
        idle();
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_contention();
    test_read_routing();
    test_write_read();
    test_cross_port();
    test_reset_midflight();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
Two-requester front end that merges port A and port B memory requests onto the single write_en/read_en/addr/w_data/r_data memory channel of the dual-port RAM subsystem. It sits directly upstream of the memory interface and drives it. Round-robin arbitration with valid/ready handshakes on each requester. Read data is returned only to the requester that issued the read, in issue order.

Parameters:
DATA_WIDTH, 32, width of write/read data
ADDR_WIDTH, 32, width of memory address
RD_LATENCY, 1, cycles from mem_read_en sampled high to mem_r_data valid (legal 1..4)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
a_req_valid  input  1  port A request present
a_req_ready  output  1  port A request accepted this cycle
a_req_wr  input  1  1=write, 0=read
a_req_addr  input  ADDR_WIDTH  port A address
a_req_wdata  input  DATA_WIDTH  port A write data
a_rvalid  output  1  port A read data valid (1-cycle pulse)
a_rdata  output  DATA_WIDTH  port A read data
b_req_valid, b_req_ready, b_req_wr, b_req_addr, b_req_wdata, b_rvalid, b_rdata  as port A
mem_write_en  output  1  memory write strobe
mem_read_en  output  1  memory read strobe
mem_addr  output  ADDR_WIDTH  memory address
mem_w_data  output  DATA_WIDTH  memory write data
mem_r_data  input  DATA_WIDTH  memory read data

Behaviour:
- One clock (clk); reset is asynchronous and active-low. While reset low: all outputs 0, priority pointer = A, read tag pipe cleared.
- Handshake: transfer on a port when req_valid && req_ready at a rising edge. req_ready is combinational from the grant; at most one port ready per cycle. Requesters hold valid/payload stable until ready.
- Arbitration: only A valid -> grant A; only B valid -> grant B; both valid -> grant priority holder. Pointer flips to the other port after any grant; unchanged in idle cycles. No backpressure from memory: one grant per cycle possible, 100% throughput.
- Issue: request accepted at edge N drives mem_* (registered) during cycle N+1: write -> mem_write_en=1, mem_addr, mem_w_data; read -> mem_read_en=1, mem_addr, mem_w_data=0. mem_write_en and mem_read_en never both 1. No grant -> both strobes 0, addr/data hold last value.
- Read return: each issued read pushes {valid, port_id} into a RD_LATENCY-deep tag pipe aligned to mem_r_data. When tag valid, mem_r_data is registered into the owner's rdata and its rvalid pulses for 1 cycle: rvalid in cycle N+2+RD_LATENCY for a read accepted at edge N. Non-owner rvalid stays 0; rdata holds last value.
- Ordering: memory ops issued strictly in grant order; a write then read to the same address from any ports in consecutive grants returns the written data (RAM guarantees write-then-read visibility next cycle).
- Back-to-back reads: one response per cycle, no bubbles, no loss.
- Reset mid-operation: in-flight reads discarded; no rvalid after reset release until a new read is issued.
- Writes produce no response.

Decomposition:
- Package mem_pkg: DATA_WIDTH/ADDR_WIDTH defaults, typedef mem_req_t {wr, addr, wdata}, typedef enum port_id_t {PORT_A, PORT_B}, typedef rd_tag_t {valid, port_id_t}.
- One sub-module: rd_tag_pipe (parameterized RD_LATENCY shift register of rd_tag_t, async active-low clear).

Test Plan:
- Reset: hold reset=0 with a_req_valid=1 -> all outputs 0, a_req_ready=0; release -> first grant to A.
- Single write/read: A writes 0xDEADBEEF @ 0x10 at edge N -> mem_write_en=1, mem_addr=0x10 in N+1; A reads 0x10 at edge N+1 -> a_rvalid=1, a_rdata=0xDEADBEEF in N+3+RD_LATENCY, b_rvalid=0.
- Contention: A and B both valid 6 cycles -> grants A,B,A,B,A,B; each ready exactly 3 times.
- Read routing: B reads 0x20 (holds 0x1111), A reads 0x24 (holds 0x2222) in consecutive grants -> b_rvalid/b_rdata=0x1111 then next cycle a_rvalid/a_rdata=0x2222.
- Reset mid-flight: A read accepted, reset asserted before return -> no a_rvalid after release.
- RD_LATENCY=3: 8 back-to-back A reads -> 8 consecutive a_rvalid pulses, data in address order.
